// File: rtl/ekf_stage_seq_pkg.sv
// rtl/ekf_stage_seq_pkg.sv - stage codes, command encodings and FSM states shared with PE_config
package ekf_pkg;

    localparam logic [2:0] STAGE_BUSY  = 3'b000;
    localparam logic [2:0] STAGE_PRD   = 3'b001;
    localparam logic [2:0] STAGE_NEW   = 3'b010;
    localparam logic [2:0] STAGE_UPD   = 3'b100;
    localparam logic [2:0] STAGE_READY = 3'b111;

    localparam logic [1:0] CMD_PREDICT = 2'b00;
    localparam logic [1:0] CMD_OBSERVE = 2'b01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        RETIRE = 3'd3,
        ERR    = 3'd4
    } state_t;

endpackage

// File: rtl/ekf_stage_seq_if.sv
// rtl/ekf_stage_seq_if.sv - host command handshake and PE_config stage handshake bundle
interface ekf_stage_seq_if #(
    parameter int ROW_LEN = 10
);
    logic               cmd_val;
    logic               cmd_rdy;
    logic [1:0]         cmd_type;
    logic [ROW_LEN-1:0] cmd_lm_id;
    logic [2:0]         stage_val;
    logic [2:0]         stage_rdy;
    logic [ROW_LEN-1:0] landmark_num;
    logic [ROW_LEN-1:0] lm_id;

    modport master (
        output cmd_val, cmd_type, cmd_lm_id, stage_rdy,
        input  cmd_rdy, stage_val, landmark_num, lm_id
    );

    modport slave (
        input  cmd_val, cmd_type, cmd_lm_id, stage_rdy,
        output cmd_rdy, stage_val, landmark_num, lm_id
    );
endinterface

// File: rtl/ekf_stage_seq_classify.sv
// rtl/ekf_stage_seq_classify.sv - decode of a command into a stage code or a rejection
module ekf_cmd_classify
    import ekf_pkg::*;
#(
    parameter int ROW_LEN      = 10,
    parameter int MAX_LANDMARK = 500
) (
    input  logic [1:0]         cmd_type,
    input  logic [ROW_LEN-1:0] cmd_lm_id,
    input  logic [ROW_LEN-1:0] landmark_num,
    output logic [2:0]         code,
    output logic               reject
);
    localparam logic [ROW_LEN-1:0] MAX_L = ROW_LEN'(MAX_LANDMARK);

    // A new landmark must be the next free id; anything beyond it is a host error.
    always_comb begin
        code   = STAGE_BUSY;
        reject = 1'b1;
        case (cmd_type)
            CMD_PREDICT: begin
                code   = STAGE_PRD;
                reject = 1'b0;
            end
            CMD_OBSERVE: begin
                if (cmd_lm_id < landmark_num) begin
                    code   = STAGE_UPD;
                    reject = 1'b0;
                end else if (cmd_lm_id == landmark_num && landmark_num < MAX_L) begin
                    code   = STAGE_NEW;
                    reject = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ekf_stage_seq.sv
// rtl/ekf_stage_seq.sv - predict/observe stage sequencer feeding PE_config
module ekf_stage_seq
    import ekf_pkg::*;
#(
    parameter int ROW_LEN      = 10,
    parameter int MAX_LANDMARK = 500,
    parameter int CYC_W        = 16
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    ekf_stage_seq_if.slave     bus,
    input  logic               lm_clr,
    output logic               busy,
    output logic               done_val,
    output logic [2:0]         done_stage,
    output logic [CYC_W-1:0]   stage_cycles,
    output logic               err
);
    state_t             state;
    logic               rdy_en;
    logic [2:0]         stage_val;
    logic [2:0]         cur_code;
    logic [ROW_LEN-1:0] landmark_num;
    logic [ROW_LEN-1:0] lm_id;
    logic [CYC_W-1:0]   cnt;
    logic [CYC_W-1:0]   cnt_inc;
    logic [2:0]         cls_code;
    logic               cls_reject;
    logic               accept;

    ekf_cmd_classify #(
        .ROW_LEN      (ROW_LEN),
        .MAX_LANDMARK (MAX_LANDMARK)
    ) u_classify (
        .cmd_type     (bus.cmd_type),
        .cmd_lm_id    (bus.cmd_lm_id),
        .landmark_num (landmark_num),
        .code         (cls_code),
        .reject       (cls_reject)
    );

    // rdy_en keeps cmd_rdy low while reset is held and for the first cycle after.
    assign bus.cmd_rdy      = rdy_en && (state == IDLE) && (bus.stage_rdy == STAGE_READY) && !lm_clr;
    assign accept           = bus.cmd_val && bus.cmd_rdy;
    assign cnt_inc          = (&cnt) ? cnt : cnt + 1'b1;
    assign bus.stage_val    = stage_val;
    assign bus.landmark_num = landmark_num;
    assign bus.lm_id        = lm_id;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            rdy_en       <= 1'b0;
            stage_val    <= STAGE_BUSY;
            cur_code     <= STAGE_BUSY;
            landmark_num <= '0;
            lm_id        <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done_val     <= 1'b0;
            done_stage   <= STAGE_BUSY;
            stage_cycles <= '0;
            err          <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            done_val <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (lm_clr) begin
                        landmark_num <= '0;
                    end else if (accept) begin
                        busy <= 1'b1;
                        if (cls_reject) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            stage_val <= cls_code;
                            cur_code  <= cls_code;
                            lm_id     <= (cls_code == STAGE_PRD) ? '0 : bus.cmd_lm_id;
                            cnt       <= {{(CYC_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt_inc;
                    if (bus.stage_rdy == STAGE_BUSY) begin
                        stage_val <= STAGE_BUSY;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.stage_rdy == STAGE_READY) begin
                        state        <= RETIRE;
                        done_val     <= 1'b1;
                        done_stage   <= cur_code;
                        stage_cycles <= cnt;
                        if (cur_code == STAGE_NEW) landmark_num <= landmark_num + 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RETIRE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ekf_stage_seq.sv
// tb/tb_ekf_stage_seq.sv - scoreboard bench for ekf_stage_seq
module tb_ekf_stage_seq;
    import ekf_pkg::*;

    typedef struct packed {
        logic [2:0]  code;
        logic [15:0] cycles;
        logic [9:0]  lm;
    } exp_t;

    logic        clk;
    logic        sys_rst_n;
    logic        lm_clr;
    logic        busy;
    logic        done_val;
    logic [2:0]  done_stage;
    logic [15:0] stage_cycles;
    logic        err;

    int          n_tests;
    int          n_fail;
    logic [9:0]  lm_model;
    exp_t        sb[$];

    ekf_stage_seq_if #(.ROW_LEN(10)) bus();

    ekf_stage_seq #(
        .ROW_LEN      (10),
        .MAX_LANDMARK (500),
        .CYC_W        (16)
    ) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .bus          (bus.slave),
        .lm_clr       (lm_clr),
        .busy         (busy),
        .done_val     (done_val),
        .done_stage   (done_stage),
        .stage_cycles (stage_cycles),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_val === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: stage=%b cycles=%0d, no retire expected", done_stage, stage_cycles);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (done_stage !== e.code || stage_cycles !== e.cycles || bus.landmark_num !== e.lm) begin
                    n_fail++;
                    $display("FAIL done_retire: stage=%b cycles=%0d lm=%0d, expected stage=%b cycles=%0d lm=%0d",
                             done_stage, stage_cycles, bus.landmark_num, e.code, e.cycles, e.lm);
                end
            end
        end
    end

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_rdy_timeout: cmd_rdy=%b, expected 1 within 20 cycles", bus.cmd_rdy);
        end
    endtask

    // Issue one command; PE drops stage_rdy at cycle T+a and returns it at T+r.
    task automatic run_stage(input logic [1:0] typ, input logic [9:0] id, input logic [2:0] code,
                             input int a, input int r, input bit clr_pulse);
        exp_t       e;
        bit         ok;
        logic [9:0] lm_before;
        wait_rdy(ok);
        if (!ok) return;
        lm_before     = lm_model;
        bus.cmd_val   = 1'b1;
        bus.cmd_type  = typ;
        bus.cmd_lm_id = id;
        e.code   = code;
        e.cycles = 16'(r);
        e.lm     = (code == STAGE_NEW) ? lm_model + 10'd1 : lm_model;
        sb.push_back(e);
        lm_model = e.lm;
        for (int k = 1; k <= r + 1; k++) begin
            @(negedge clk);
            bus.cmd_val   = 1'b0;
            bus.cmd_type  = 2'($urandom);
            bus.cmd_lm_id = 10'($urandom);
            lm_clr        = clr_pulse && (k == 2);
            n_tests++;
            if (k <= a) begin
                if (bus.stage_val !== code) begin
                    n_fail++;
                    $display("FAIL stage_val_held: k=%0d got=%b, expected %b", k, bus.stage_val, code);
                end
            end else if (bus.stage_val !== STAGE_BUSY) begin
                n_fail++;
                $display("FAIL stage_val_drop: k=%0d got=%b, expected 000", k, bus.stage_val);
            end
            if (k == 1) begin
                n_tests++;
                if (bus.lm_id !== ((code == STAGE_PRD) ? 10'd0 : id) || bus.landmark_num !== lm_before || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL issue_state: lm_id=%0d lm=%0d busy=%b, expected lm_id=%0d lm=%0d busy=1",
                             bus.lm_id, bus.landmark_num, busy, (code == STAGE_PRD) ? 10'd0 : id, lm_before);
                end
            end
            if (k == a) bus.stage_rdy = STAGE_BUSY;
            if (k == r) bus.stage_rdy = STAGE_READY;
        end
        lm_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0 || bus.stage_val !== STAGE_BUSY || bus.cmd_rdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: pending=%0d stage_val=%b cmd_rdy=%b busy=%b, expected 0 000 1 0",
                     sb.size(), bus.stage_val, bus.cmd_rdy, busy);
            sb.delete();
        end
    endtask

    task automatic run_err(input logic [1:0] typ, input logic [9:0] id);
        bit ok;
        wait_rdy(ok);
        if (!ok) return;
        bus.cmd_val   = 1'b1;
        bus.cmd_type  = typ;
        bus.cmd_lm_id = id;
        @(negedge clk);
        bus.cmd_val = 1'b0;
        n_tests++;
        if (err !== 1'b1 || bus.stage_val !== STAGE_BUSY || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_pulse: err=%b stage_val=%b busy=%b, expected 1 000 1", err, bus.stage_val, busy);
        end
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0 || bus.cmd_rdy !== 1'b1 || bus.landmark_num !== lm_model) begin
            n_fail++;
            $display("FAIL err_recover: err=%b cmd_rdy=%b lm=%0d, expected 0 1 %0d",
                     err, bus.cmd_rdy, bus.landmark_num, lm_model);
        end
    endtask

    task automatic test_reset();
        sys_rst_n     = 1'b0;
        lm_clr        = 1'b0;
        bus.cmd_val   = 1'b0;
        bus.cmd_type  = CMD_PREDICT;
        bus.cmd_lm_id = '0;
        bus.stage_rdy = STAGE_READY;
        lm_model      = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.stage_val, bus.cmd_rdy, bus.landmark_num, bus.lm_id, busy, done_val, done_stage, stage_cycles, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: stage_val=%b cmd_rdy=%b lm=%0d lm_id=%0d busy=%b done=%b stage=%b cyc=%0d err=%b, expected all 0",
                     bus.stage_val, bus.cmd_rdy, bus.landmark_num, bus.lm_id, busy, done_val, done_stage, stage_cycles, err);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.cmd_rdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_rdy=%b busy=%b, expected 1 0", bus.cmd_rdy, busy);
        end
    endtask

    task automatic test_new_first();
        run_stage(CMD_OBSERVE, 10'd0, STAGE_NEW, 3, 8, 1'b0);
    endtask

    task automatic test_predict();
        for (int i = 1; i < 5; i++) run_stage(CMD_OBSERVE, lm_model, STAGE_NEW, 1, 2, 1'b0);
        run_stage(CMD_PREDICT, 10'd9, STAGE_PRD, 4, 11, 1'b0);
    endtask

    task automatic test_update_and_err();
        run_stage(CMD_OBSERVE, 10'd3, STAGE_UPD, 2, 5, 1'b0);
        run_err(CMD_OBSERVE, 10'd7);
    endtask

    task automatic test_long_accept();
        run_stage(CMD_OBSERVE, 10'd4, STAGE_UPD, 7, 10, 1'b1);
    endtask

    task automatic test_fill();
        while (lm_model < 10'd500) run_stage(CMD_OBSERVE, lm_model, STAGE_NEW, 1, 2, 1'b0);
        run_err(CMD_OBSERVE, 10'd500);
        run_err(2'b11, 10'd0);
        run_err(2'b10, 10'd1);
        run_stage(CMD_OBSERVE, 10'd499, STAGE_UPD, 1, 3, 1'b0);
    endtask

    task automatic test_lm_clr_idle();
        lm_clr = 1'b1;
        #1;
        n_tests++;
        if (bus.cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL lm_clr_rdy: cmd_rdy=%b, expected 0", bus.cmd_rdy);
        end
        @(negedge clk);
        lm_clr   = 1'b0;
        lm_model = '0;
        #1;
        n_tests++;
        if (bus.landmark_num !== 10'd0 || bus.cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL lm_clr_idle: lm=%0d cmd_rdy=%b, expected 0 1", bus.landmark_num, bus.cmd_rdy);
        end
        run_stage(CMD_OBSERVE, 10'd0, STAGE_NEW, 2, 4, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_rdy(ok);
        if (!ok) return;
        bus.cmd_val  = 1'b1;
        bus.cmd_type = CMD_PREDICT;
        @(negedge clk);
        bus.cmd_val   = 1'b0;
        bus.stage_rdy = STAGE_BUSY;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || bus.stage_val !== STAGE_BUSY) begin
            n_fail++;
            $display("FAIL wait_state: busy=%b stage_val=%b, expected 1 000", busy, bus.stage_val);
        end
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || bus.landmark_num !== 10'd0 || bus.cmd_rdy !== 1'b0 || done_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: busy=%b lm=%0d cmd_rdy=%b done=%b, expected 0 0 0 0",
                     busy, bus.landmark_num, bus.cmd_rdy, done_val);
        end
        lm_model = '0;
        @(negedge clk);
        bus.stage_rdy = STAGE_READY;
        @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_stage(CMD_PREDICT, 10'd0, STAGE_PRD, 2, 6, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        @(negedge clk);
        test_reset();
        test_new_first();
        test_predict();
        test_update_and_err();
        test_long_accept();
        test_fill();
        test_lm_clr_idle();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ekf_stage_seq.md
Name: ekf_stage_seq

Overview:
Stage sequencer directly upstream of PE_config in the EKF-SLAM RSA datapath. Accepts predict/observe commands from the host side and classifies each observation as new-landmark or update. Issues the one-hot stage_val to PE_config and tracks its stage_rdy handshake. Owns the landmark_num count consumed by PE_config, retires each stage and reports its cycle count.

Parameters:
ROW_LEN, 10, width of landmark_num and landmark ids
MAX_LANDMARK, 500, maximum landmark count; new-landmark beyond this is rejected
CYC_W, 16, width of stage cycle counter

Ports:
clk  in  1  system clock
sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
cmd_val  in  1  command valid
cmd_rdy  out  1  command ready
cmd_type  in  2  00 predict, 01 observe, 10/11 illegal
cmd_lm_id  in  ROW_LEN  observed landmark id (observe only)
lm_clr  in  1  clear landmark_num (honoured in IDLE only)
stage_val  out  3  one-hot to PE_config: 001 PRD, 010 NEW, 100 UPD
stage_rdy  in  3  from PE_config: 111 ready, 000 busy
landmark_num  out  ROW_LEN  current landmark count to PE_config
lm_id  out  ROW_LEN  id of landmark being processed (0 for PRD)
busy  out  1  high in any state but IDLE
done_val  out  1  one-cycle retire pulse
done_stage  out  3  stage code retired, valid with done_val
stage_cycles  out  CYC_W  cycles from first stage_val to stage_rdy return, valid with done_val
err  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset (async assert, sync release): state IDLE; stage_val=000, cmd_rdy=0, landmark_num=0, lm_id=0, busy=0, done_val=0, done_stage=000, stage_cycles=0, err=0. Reset mid-stage abandons the stage; no done_val is produced.
- FSM: IDLE -> ISSUE -> WAIT -> RETIRE -> IDLE. A rejected command takes IDLE -> ERR -> IDLE.
- IDLE: cmd_rdy=1 iff stage_rdy==111 and lm_clr==0. lm_clr in IDLE sets landmark_num=0 next cycle and holds cmd_rdy low that cycle. lm_clr in other states is ignored.
- Accept on cmd_val&cmd_rdy at cycle T. Classify:
  - predict -> PRD.
  - observe with id<landmark_num -> UPD.
  - observe with id==landmark_num and landmark_num<MAX_LANDMARK -> NEW.
  - Anything else (id>landmark_num, id==landmark_num==MAX_LANDMARK, type 10/11) -> ERR.
  - lm_id is registered at T+1.
- ISSUE: stage_val registered high from T+1 and held until stage_rdy==000 is sampled (acceptance). The cycle counter starts at 1 on the first ISSUE cycle.
- WAIT: stage_val=000; counter increments each cycle; leave when stage_rdy==111.
- RETIRE (1 cycle): done_val=1, done_stage=issued code, stage_cycles=counter (saturates at all-ones). On NEW, landmark_num increments in the same cycle. Next cycle is IDLE; cmd_rdy may rise then.
- ERR (1 cycle, T+1): err=1; no stage_val, no count change; IDLE at T+2.
- stage_rdy values other than 000/111 are treated as not-ready in IDLE, and as not-accepted/not-returned in ISSUE/WAIT.
- cmd_* are sampled only on acceptance; changes at other times are ignored.

Decomposition:
- Package ekf_pkg holds:
  - stage codes STAGE_PRD=3'b001, STAGE_NEW=3'b010, STAGE_UPD=3'b100, STAGE_BUSY=3'b000, STAGE_READY=3'b111
  - cmd_type encodings
  - state enum IDLE/ISSUE/WAIT/RETIRE/ERR
  - this package is shared with PE_config.
- One sub-module is natural: ekf_cmd_classify, a combinational cmd_type/id/landmark_num -> stage code or error decode.
- FSM and counters stay in the top.

Test Plan:
- Reset, landmark_num=0, stage_rdy=111; cmd observe id=0 at T -> stage_val=010 at T+1. Model drops stage_rdy to 000 at T+3 and returns 111 at T+8 -> done_val with done_stage=010; landmark_num=1 in the RETIRE cycle.
- landmark_num=5; predict -> stage_val=001 held until stage_rdy=000; done_stage=001; stage_cycles matches model latency exactly; landmark_num stays 5.
- landmark_num=5; observe id=3 -> stage_val=100, lm_id=3, landmark_num stays 5. Observe id=7 -> err pulse at T+1, stage_val stays 000, cmd_rdy=1 at T+2.
- Fill to landmark_num=500; observe id=500 -> err, count stays 500. cmd_type=11 -> err.
- Delay stage_rdy=000 by 6 cycles -> stage_val held 6+ cycles, single stage only. Pulse lm_clr while busy -> ignored. Pulse lm_clr in IDLE -> landmark_num=0, cmd_rdy low that cycle.
- Assert sys_rst_n low during WAIT -> outputs reset immediately, no done_val. After release, a new predict completes normally.
